// File: rtl/sysx_slave_port.sv
// sysX slave endpoint: samples the master's bus clock, select and MOSI into
// the local clock domain, decodes one command byte plus four data bytes, and
// turns them into single-cycle local register read/write strobes. Read data
// is returned MSB byte first on MISO. Also holds a level interrupt latch that
// is cleared by a completed read of a chosen register index.
module sysx_slave_port #(
    parameter logic [1:0] pAddress  = 2'd1,
    parameter logic [6:0] pIrqIndex = 7'h7F
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iBusClock,
    input  logic [1:0]  iBusSelect,
    input  logic [7:0]  iBusMOSI,
    output logic [7:0]  oBusMISO,
    output logic        oBusInterrupt,
    output logic [6:0]  oRegAddr,
    output logic [31:0] oRegData,
    output logic        oRegWrite,
    output logic        oRegRead,
    input  logic [31:0] iRegData,
    input  logic        iIrqRequest
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_BEGIN    = 3'd1;
    localparam logic [2:0] ST_HIGHHIGH = 3'd2;
    localparam logic [2:0] ST_HIGH     = 3'd3;
    localparam logic [2:0] ST_LOW      = 3'd4;
    localparam logic [2:0] ST_LOWLOW   = 3'd5;
    localparam logic [2:0] ST_END      = 3'd6;
    localparam logic [2:0] ST_INVALID  = 3'd7;

    // Two-stage synchronizers for the asynchronous bus inputs
    logic       clk_s1_q, clk_s2_q, clk_prev_q;
    logic [1:0] sel_s1_q, sel_s2_q;
    logic [7:0] mosi_s1_q, mosi_s2_q;

    // Transaction state
    logic [2:0]  state_q,    state_d;
    logic        is_write_q, is_write_d;
    logic [6:0]  addr_q,     addr_d;
    logic [31:0] data_q,     data_d;
    logic [23:0] shift_q,    shift_d;
    logic [31:0] rdata_q,    rdata_d;
    logic [7:0]  miso_q,     miso_d;
    logic        write_q,    write_d;
    logic        read_q,     read_d;
    logic        read_dly_q, read_dly_d;
    logic        irq_q,      irq_d;
    logic        int_q,      int_d;
    logic        armed_q,    armed_d;
    logic [1:0]  sync_vld_q, sync_vld_d;

    logic sel_s;
    logic e_s;
    logic clr_s;

    // Synchronize bus clock, select and MOSI with matching latency so the
    // sampled MOSI byte lines up with the detected bus-clock edge
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            clk_s1_q   <= 1'b0;
            clk_s2_q   <= 1'b0;
            clk_prev_q <= 1'b0;
            sel_s1_q   <= 2'b00;
            sel_s2_q   <= 2'b00;
            mosi_s1_q  <= 8'h00;
            mosi_s2_q  <= 8'h00;
        end else begin
            clk_s1_q   <= iBusClock;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            sel_s1_q   <= iBusSelect;
            sel_s2_q   <= sel_s1_q;
            mosi_s1_q  <= iBusMOSI;
            mosi_s2_q  <= mosi_s1_q;
        end
    end

    assign sel_s = (sel_s2_q == pAddress);
    assign e_s   = clk_s2_q & ~clk_prev_q;

    // Next-state, datapath and strobe decode for one bus transaction
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        shift_d    = shift_q;
        rdata_d    = rdata_q;
        miso_d     = miso_q;
        write_d    = 1'b0;
        read_d     = 1'b0;
        read_dly_d = 1'b0;
        clr_s      = 1'b0;
        sync_vld_d = {sync_vld_q[0], 1'b1};

        // A new transaction may only start after select has been seen
        // inactive once the synchronizers hold real data; this stops a select
        // that was held through reset from restarting a transaction.
        if (sync_vld_q[1] && !sel_s) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end

        if (!sel_s) begin
            state_d = ST_IDLE;
            miso_d  = 8'h00;
        end else begin
            read_dly_d = read_q;
            case (state_q)
                ST_IDLE: begin
                    if (armed_q) begin
                        state_d = ST_BEGIN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BEGIN: begin
                    if (e_s) begin
                        state_d    = ST_HIGHHIGH;
                        is_write_d = mosi_s2_q[7];
                        addr_d     = mosi_s2_q[6:0];
                        read_d     = ~mosi_s2_q[7];
                        shift_d    = 24'h000000;
                    end else begin
                        state_d = ST_BEGIN;
                    end
                end
                ST_HIGHHIGH: begin
                    if (e_s) begin
                        state_d = ST_HIGH;
                        if (is_write_q) begin
                            shift_d = {shift_q[15:0], mosi_s2_q};
                        end else begin
                            miso_d = rdata_q[23:16];
                        end
                    end else begin
                        state_d = ST_HIGHHIGH;
                    end
                end
                ST_HIGH: begin
                    if (e_s) begin
                        state_d = ST_LOW;
                        if (is_write_q) begin
                            shift_d = {shift_q[15:0], mosi_s2_q};
                        end else begin
                            miso_d = rdata_q[15:8];
                        end
                    end else begin
                        state_d = ST_HIGH;
                    end
                end
                ST_LOW: begin
                    if (e_s) begin
                        state_d = ST_LOWLOW;
                        if (is_write_q) begin
                            shift_d = {shift_q[15:0], mosi_s2_q};
                        end else begin
                            miso_d = rdata_q[7:0];
                        end
                    end else begin
                        state_d = ST_LOW;
                    end
                end
                ST_LOWLOW: begin
                    if (e_s) begin
                        state_d = ST_END;
                        miso_d  = 8'h00;
                        if (is_write_q) begin
                            // Only a complete word reaches oRegData
                            data_d  = {shift_q, mosi_s2_q};
                            write_d = 1'b1;
                        end else begin
                            clr_s = (addr_q == pIrqIndex);
                        end
                    end else begin
                        state_d = ST_LOWLOW;
                    end
                end
                ST_END: begin
                    if (e_s) begin
                        state_d = ST_INVALID;
                        miso_d  = 8'hFF;
                    end else begin
                        state_d = ST_END;
                    end
                end
                ST_INVALID: begin
                    state_d = ST_INVALID;
                    miso_d  = 8'hFF;
                end
                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 8'h00;
                end
            endcase

            // Peripheral data is valid the cycle after the read strobe
            if (read_dly_q && (state_q == ST_HIGHHIGH)) begin
                rdata_d = iRegData;
                miso_d  = iRegData[31:24];
            end else begin
                rdata_d = rdata_d;
            end
        end

        // A new request wins over a simultaneous clear
        if (iIrqRequest) begin
            irq_d = 1'b1;
        end else if (clr_s) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
        int_d = irq_q;
    end

    // State and output registers
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= 7'h00;
            data_q     <= 32'h00000000;
            shift_q    <= 24'h000000;
            rdata_q    <= 32'h00000000;
            miso_q     <= 8'h00;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            read_dly_q <= 1'b0;
            irq_q      <= 1'b0;
            int_q      <= 1'b0;
            armed_q    <= 1'b0;
            sync_vld_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            rdata_q    <= rdata_d;
            miso_q     <= miso_d;
            write_q    <= write_d;
            read_q     <= read_d;
            read_dly_q <= read_dly_d;
            irq_q      <= irq_d;
            int_q      <= int_d;
            armed_q    <= armed_d;
            sync_vld_q <= sync_vld_d;
        end
    end

    assign oBusMISO      = miso_q;
    assign oBusInterrupt = int_q;
    assign oRegAddr      = addr_q;
    assign oRegData      = data_q;
    assign oRegWrite     = write_q;
    assign oRegRead      = read_q;

endmodule

// File: tb/tb_sysx_slave_port.sv
// Bench for sysx_slave_port: table of bus transactions with expected strobes,
// a strobe scoreboard fed by the stimulus, plus hand-written reset and
// interrupt sequences.
module tb_sysx_slave_port;

    localparam int HALF = 8;

    logic        iClock = 1'b0;
    logic        iReset;
    logic        iBusClock;
    logic [1:0]  iBusSelect;
    logic [7:0]  iBusMOSI;
    logic [7:0]  oBusMISO;
    logic        oBusInterrupt;
    logic [6:0]  oRegAddr;
    logic [31:0] oRegData;
    logic        oRegWrite;
    logic        oRegRead;
    logic [31:0] iRegData;
    logic        iIrqRequest;

    sysx_slave_port #(.pAddress(2'd1), .pIrqIndex(7'h7F)) dut (
        .iClock(iClock), .iReset(iReset), .iBusClock(iBusClock),
        .iBusSelect(iBusSelect), .iBusMOSI(iBusMOSI), .oBusMISO(oBusMISO),
        .oBusInterrupt(oBusInterrupt), .oRegAddr(oRegAddr), .oRegData(oRegData),
        .oRegWrite(oRegWrite), .oRegRead(oRegRead), .iRegData(iRegData),
        .iIrqRequest(iIrqRequest)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  cmd;
        logic [31:0] data;
        int          nb;
        logic        exp_wr;
        logic        exp_rd;
        logic [6:0]  exp_addr;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    logic [38:0] wq[$];
    logic [6:0]  rq[$];
    logic [38:0] exp_w;
    logic [6:0]  exp_r;
    vec_t vecs[8];
    vec_t v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_miso(input logic sel_ok, input logic wr,
                                            input logic [31:0] data, input int k);
        logic [31:0] t;
        if (!sel_ok)      return 8'h00;
        else if (k >= 5)  return 8'hFF;
        else if (k == 4)  return 8'h00;
        else if (wr)      return 8'h00;
        t = data >> ((3 - k) * 8);
        return t[7:0];
    endfunction

    // Scoreboard: every strobe must match the oldest pending expectation
    always @(negedge iClock) begin
        if (oRegWrite === 1'b1) begin
            if (wq.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_write: addr=%h data=%h, none expected", oRegAddr, oRegData);
            end else begin
                exp_w = wq.pop_front();
                chk("write_addr", {25'h0, oRegAddr}, {25'h0, exp_w[38:32]});
                chk("write_data", oRegData, exp_w[31:0]);
            end
        end
        if (oRegRead === 1'b1) begin
            if (rq.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_read: addr=%h, none expected", oRegAddr);
            end else begin
                exp_r = rq.pop_front();
                chk("read_addr", {25'h0, oRegAddr}, {25'h0, exp_r});
            end
        end
    end

    // One bus byte: low phase with MOSI set up, then high phase. Optionally
    // pulse iIrqRequest in exactly the cycle the slave acts on the edge.
    task automatic send_byte(input logic [7:0] b, input bit irq_at_e);
        @(negedge iClock);
        iBusClock = 1'b0;
        iBusMOSI  = b;
        repeat (HALF) @(negedge iClock);
        iBusClock = 1'b1;
        if (irq_at_e) begin
            repeat (2) @(negedge iClock);
            iIrqRequest = 1'b1;
            @(negedge iClock);
            iIrqRequest = 1'b0;
            repeat (HALF - 3) @(negedge iClock);
        end else begin
            repeat (HALF) @(negedge iClock);
        end
    endtask

    task automatic xact(input vec_t t, input int idx, input bit irq_last);
        logic        sel_ok;
        logic [7:0]  b;
        logic [31:0] sh;
        sel_ok = (t.sel == 2'd1);
        iRegData   = t.data;
        iBusClock  = 1'b0;
        iBusSelect = t.sel;
        if (t.exp_wr) wq.push_back({t.exp_addr, t.data});
        if (t.exp_rd) rq.push_back(t.exp_addr);
        repeat (6) @(negedge iClock);
        for (int k = 0; k <= t.nb; k++) begin
            if (k == 0) begin
                b = t.cmd;
            end else if (k <= 4) begin
                sh = t.data >> ((4 - k) * 8);
                b  = sh[7:0];
            end else begin
                b = 8'h5A;
            end
            send_byte(b, irq_last && (k == t.nb));
            chk($sformatf("v%0d_miso_k%0d", idx, k), {24'h0, oBusMISO},
                {24'h0, exp_miso(sel_ok, t.cmd[7], t.data, k)});
        end
        @(negedge iClock);
        iBusClock  = 1'b0;
        iBusSelect = 2'd0;
        repeat (6) @(negedge iClock);
        chk($sformatf("v%0d_miso_desel", idx), {24'h0, oBusMISO}, 32'h0);
        chk($sformatf("v%0d_wq_empty", idx), wq.size(), 32'h0);
        chk($sformatf("v%0d_rq_empty", idx), rq.size(), 32'h0);
    endtask

    initial begin
        iReset      = 1'b1;
        iBusClock   = 1'b0;
        iBusSelect  = 2'd0;
        iBusMOSI    = 8'h00;
        iRegData    = 32'h0;
        iIrqRequest = 1'b0;

        vecs[0] = '{2'd1, 8'h85, 32'hDEADBEEF, 4, 1'b1, 1'b0, 7'h05};
        vecs[1] = '{2'd1, 8'h12, 32'h0BADC0DE, 4, 1'b0, 1'b1, 7'h12};
        vecs[2] = '{2'd1, 8'h85, 32'h11223344, 2, 1'b0, 1'b0, 7'h05};
        vecs[3] = '{2'd1, 8'h83, 32'hCAFEF00D, 4, 1'b1, 1'b0, 7'h03};
        vecs[4] = '{2'd2, 8'h85, 32'h55667788, 4, 1'b0, 1'b0, 7'h05};
        vecs[5] = '{2'd1, 8'h9A, 32'hA5A55A5A, 5, 1'b1, 1'b0, 7'h1A};
        vecs[6] = '{2'd1, 8'h00, 32'h13579BDF, 5, 1'b0, 1'b1, 7'h00};
        vecs[7] = '{2'd3, 8'h12, 32'h0BADC0DE, 4, 1'b0, 1'b0, 7'h12};

        repeat (3) @(negedge iClock);
        chk("rst_miso", {24'h0, oBusMISO}, 32'h0);
        chk("rst_write", {31'h0, oRegWrite}, 32'h0);
        chk("rst_read", {31'h0, oRegRead}, 32'h0);
        chk("rst_addr", {25'h0, oRegAddr}, 32'h0);
        chk("rst_data", oRegData, 32'h0);
        chk("rst_int", {31'h0, oBusInterrupt}, 32'h0);
        iReset = 1'b0;
        repeat (5) @(negedge iClock);

        for (int i = 0; i < 8; i++) begin
            xact(vecs[i], i, 1'b0);
        end

        // Reset in the middle of a write, select held through reset
        iBusSelect = 2'd1;
        repeat (6) @(negedge iClock);
        send_byte(8'h85, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("mid_addr_before_rst", {25'h0, oRegAddr}, 32'h05);
        @(negedge iClock);
        iReset = 1'b1;
        @(negedge iClock);
        chk("mid_rst_addr", {25'h0, oRegAddr}, 32'h0);
        chk("mid_rst_miso", {24'h0, oBusMISO}, 32'h0);
        iReset = 1'b0;
        send_byte(8'h81, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        chk("no_fresh_sel_addr", {25'h0, oRegAddr}, 32'h0);
        chk("no_fresh_sel_miso", {24'h0, oBusMISO}, 32'h0);
        @(negedge iClock);
        iBusClock  = 1'b0;
        iBusSelect = 2'd0;
        repeat (6) @(negedge iClock);
        xact(vecs[0], 10, 1'b0);

        // Interrupt latch
        chk("irq_idle", {31'h0, oBusInterrupt}, 32'h0);
        iIrqRequest = 1'b1;
        @(negedge iClock);
        iIrqRequest = 1'b0;
        repeat (3) @(negedge iClock);
        chk("irq_set", {31'h0, oBusInterrupt}, 32'h1);
        v = '{2'd1, 8'h12, 32'h01020304, 4, 1'b0, 1'b1, 7'h12};
        xact(v, 11, 1'b0);
        chk("irq_other_read", {31'h0, oBusInterrupt}, 32'h1);
        v = '{2'd1, 8'h7F, 32'h89ABCDEF, 4, 1'b0, 1'b1, 7'h7F};
        xact(v, 12, 1'b0);
        chk("irq_cleared", {31'h0, oBusInterrupt}, 32'h0);
        xact(v, 13, 1'b1);
        chk("irq_set_wins", {31'h0, oBusInterrupt}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
